// File: rtl/ppu_vram_sched.sv
// PPU VRAM bus scheduler: arbitrates 2-cycle VRAM accesses between render fetches
// and a single buffered CPU $2007 access, with render always taking priority.
module ppu_vram_sched (
  input  logic        PCLK,
  input  logic        n_RES,
  input  logic        RENDER,
  input  logic [8:0]  H,
  input  logic [13:0] FETCH_ADDR,
  input  logic        CPU_REQ,
  input  logic        CPU_WR,
  input  logic [7:0]  CPU_DIN,
  input  logic        INC32,
  input  logic        V_LOAD,
  input  logic [13:0] V_IN,
  input  logic [7:0]  PD_IN,
  output logic [13:0] PA,
  output logic        ALE,
  output logic        n_RD,
  output logic        n_WR,
  output logic [7:0]  PD_OUT,
  output logic        PD_OE,
  output logic [13:0] VADDR,
  output logic [7:0]  RBUF,
  output logic        GRANT_R,
  output logic        BUSY,
  output logic        ERR
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] R_ALE = 3'd1;
  localparam logic [2:0] R_RD  = 3'd2;
  localparam logic [2:0] C_ALE = 3'd3;
  localparam logic [2:0] C_RD  = 3'd4;
  localparam logic [2:0] C_WR  = 3'd5;

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic        pend_wr;
  logic [7:0]  pend_data;
  logic        render_slot;
  logic        cpu_end;
  logic [13:0] vaddr_step;

  // Render fetches start on even dots; the range guard ignores counter values past the line end.
  assign render_slot = RENDER && !H[0] && (H < 9'd341);
  assign cpu_end     = (state == C_RD) || (state == C_WR);
  assign vaddr_step  = INC32 ? 14'd32 : 14'd1;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (render_slot)
          state_nx = R_ALE;
        else if (BUSY)
          state_nx = C_ALE;
      end
      R_ALE:     state_nx = R_RD;
      R_RD:      state_nx = render_slot ? R_ALE : IDLE;
      C_ALE:     state_nx = pend_wr ? C_WR : C_RD;
      C_RD, C_WR: state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge PCLK) begin
    if (!n_RES) begin
      state     <= IDLE;
      PA        <= '0;
      ALE       <= 1'b0;
      n_RD      <= 1'b1;
      n_WR      <= 1'b1;
      PD_OUT    <= '0;
      PD_OE     <= 1'b0;
      VADDR     <= '0;
      RBUF      <= '0;
      GRANT_R   <= 1'b0;
      BUSY      <= 1'b0;
      ERR       <= 1'b0;
      pend_wr   <= 1'b0;
      pend_data <= '0;
    end else begin
      state   <= state_nx;
      ALE     <= (state_nx == R_ALE) || (state_nx == C_ALE);
      n_RD    <= !((state_nx == R_RD) || (state_nx == C_RD));
      n_WR    <= !(state_nx == C_WR);
      PD_OE   <= (state_nx == C_WR);
      GRANT_R <= (state_nx == R_ALE) || (state_nx == R_RD);

      if (state_nx == R_ALE)
        PA <= FETCH_ADDR;
      else if (state_nx == C_ALE)
        PA <= VADDR;

      if (state_nx == C_WR)
        PD_OUT <= pend_data;

      if (state == C_RD)
        RBUF <= PD_IN;

      if (V_LOAD)
        VADDR <= V_IN;
      else if (cpu_end)
        VADDR <= VADDR + vaddr_step;

      // Only one CPU request may be outstanding; extras are dropped and flagged.
      ERR <= CPU_REQ && BUSY;
      if (CPU_REQ && !BUSY) begin
        BUSY      <= 1'b1;
        pend_wr   <= CPU_WR;
        pend_data <= CPU_DIN;
      end else if (cpu_end) begin
        BUSY <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ppu_vram_sched.sv
// Self-checking bench for ppu_vram_sched: CPU accesses are scoreboarded at request time
// and checked when the DUT strobes the bus; timing and arbitration are checked inline.
module tb_ppu_vram_sched;

  logic        PCLK = 1'b0;
  logic        n_RES;
  logic        RENDER;
  logic [8:0]  H;
  logic [13:0] FETCH_ADDR;
  logic        CPU_REQ;
  logic        CPU_WR;
  logic [7:0]  CPU_DIN;
  logic        INC32;
  logic        V_LOAD;
  logic [13:0] V_IN;
  logic [7:0]  PD_IN;
  logic [13:0] PA;
  logic        ALE;
  logic        n_RD;
  logic        n_WR;
  logic [7:0]  PD_OUT;
  logic        PD_OE;
  logic [13:0] VADDR;
  logic [7:0]  RBUF;
  logic        GRANT_R;
  logic        BUSY;
  logic        ERR;

  typedef struct {
    logic        wr;
    logic [13:0] addr;
    logic [7:0]  data;
    logic [13:0] vnext;
  } exp_t;

  exp_t        exp_q[$];
  int          assert_count = 0;
  int          fail_count = 0;
  int          render_strobes = 0;
  logic [13:0] model_v;
  logic [7:0]  pd_val;

  assign PD_IN = pd_val;

  always #5 PCLK = ~PCLK;

  ppu_vram_sched dut (
    .PCLK(PCLK), .n_RES(n_RES), .RENDER(RENDER), .H(H), .FETCH_ADDR(FETCH_ADDR),
    .CPU_REQ(CPU_REQ), .CPU_WR(CPU_WR), .CPU_DIN(CPU_DIN), .INC32(INC32),
    .V_LOAD(V_LOAD), .V_IN(V_IN), .PD_IN(PD_IN), .PA(PA), .ALE(ALE), .n_RD(n_RD),
    .n_WR(n_WR), .PD_OUT(PD_OUT), .PD_OE(PD_OE), .VADDR(VADDR), .RBUF(RBUF),
    .GRANT_R(GRANT_R), .BUSY(BUSY), .ERR(ERR)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  // Raises CPU_REQ for the next edge and records what the resulting access must look like.
  task automatic applyStimulus(input logic wr, input logic [7:0] din, input logic [13:0] vnext);
    exp_t e;
    e.wr    = wr;
    e.addr  = model_v;
    e.data  = wr ? din : pd_val;
    e.vnext = vnext;
    exp_q.push_back(e);
    model_v = vnext;
    CPU_REQ = 1'b1;
    CPU_WR  = wr;
    CPU_DIN = din;
  endtask

  task automatic set_vaddr(input logic [13:0] v);
    V_LOAD = 1'b1;
    V_IN   = v;
    tick;
    V_LOAD  = 1'b0;
    model_v = v;
  endtask

  // CPU access monitor: pops the scoreboard on each CPU strobe and checks the end-of-access edge.
  initial begin
    exp_t e;
    logic rst_edge;
    forever begin
      @(negedge PCLK);
      if ((n_RD === 1'b0 && GRANT_R === 1'b0) || n_WR === 1'b0) begin
        rst_edge = !n_RES;
        checkOutput("cpu_access_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkOutput("cpu_pa", 32'(PA), 32'(e.addr));
          checkOutput("cpu_is_write", 32'(!n_WR), 32'(e.wr));
          checkOutput("strobe_exclusive", 32'(n_RD | n_WR), 1);
          if (e.wr) begin
            checkOutput("pd_out", 32'(PD_OUT), 32'(e.data));
            checkOutput("pd_oe", 32'(PD_OE), 1);
          end
          @(posedge PCLK);
          #1;
          if (rst_edge) begin
            checkOutput("abort_vaddr", 32'(VADDR), 0);
            checkOutput("abort_rbuf", 32'(RBUF), 0);
          end else begin
            checkOutput("cpu_vaddr_next", 32'(VADDR), 32'(e.vnext));
            if (!e.wr)
              checkOutput("cpu_rbuf", 32'(RBUF), 32'(e.data));
          end
        end
      end
    end
  end

  always @(negedge PCLK) begin
    if (n_RD === 1'b0 && GRANT_R === 1'b1) begin
      render_strobes++;
      checkOutput("render_pa", 32'(PA), 32'h1234);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_RES = 1'b0; RENDER = 1'b0; H = '0; FETCH_ADDR = '0; CPU_REQ = 1'b0; CPU_WR = 1'b0;
    CPU_DIN = '0; INC32 = 1'b0; V_LOAD = 1'b0; V_IN = '0; pd_val = '0; model_v = '0;
    tick;
    tick;
    checkOutput("rst_pa", 32'(PA), 0);
    checkOutput("rst_vaddr", 32'(VADDR), 0);
    checkOutput("rst_rbuf", 32'(RBUF), 0);
    checkOutput("rst_ale", 32'(ALE), 0);
    checkOutput("rst_nrd", 32'(n_RD), 1);
    checkOutput("rst_nwr", 32'(n_WR), 1);
    checkOutput("rst_busy", 32'(BUSY), 0);
    checkOutput("rst_grant", 32'(GRANT_R), 0);
    n_RES = 1'b1;
    tick;

    // Basic read timing from IDLE
    set_vaddr(14'h2000);
    pd_val = 8'h5A;
    applyStimulus(1'b0, 8'h00, 14'h2001);
    tick;
    CPU_REQ = 1'b0;
    checkOutput("busy_t", 32'(BUSY), 1);
    checkOutput("ale_t", 32'(ALE), 0);
    tick;
    checkOutput("ale_t1", 32'(ALE), 1);
    checkOutput("pa_t1", 32'(PA), 32'h2000);
    checkOutput("nrd_t1", 32'(n_RD), 1);
    tick;
    checkOutput("nrd_t2", 32'(n_RD), 0);
    checkOutput("ale_t2", 32'(ALE), 0);
    tick;
    checkOutput("rbuf_t3", 32'(RBUF), 32'h5A);
    checkOutput("vaddr_t3", 32'(VADDR), 32'h2001);
    checkOutput("busy_t3", 32'(BUSY), 0);

    // Write with +32 step wrapping past 0x3FFF
    INC32 = 1'b1;
    set_vaddr(14'h3FF0);
    applyStimulus(1'b1, 8'hC3, 14'h0010);
    tick;
    CPU_REQ = 1'b0;
    tick;
    tick;
    checkOutput("nwr_t2", 32'(n_WR), 0);
    checkOutput("pdoe_t2", 32'(PD_OE), 1);
    checkOutput("pa_wr", 32'(PA), 32'h3FF0);
    tick;
    checkOutput("vaddr_wrap", 32'(VADDR), 32'h0010);
    checkOutput("pdoe_t3", 32'(PD_OE), 0);
    INC32 = 1'b0;

    // Second request while busy is dropped
    set_vaddr(14'h0400);
    applyStimulus(1'b1, 8'hA5, 14'h0401);
    tick;
    CPU_WR = 1'b0;
    CPU_DIN = 8'h11;
    tick;
    CPU_REQ = 1'b0;
    checkOutput("err_pulse", 32'(ERR), 1);
    checkOutput("ale_during_err", 32'(ALE), 1);
    tick;
    checkOutput("err_clear", 32'(ERR), 0);
    tick;
    checkOutput("busy_after_err", 32'(BUSY), 0);
    checkOutput("err_idle", 32'(ERR), 0);

    // V_LOAD beats the increment on the access-ending edge
    set_vaddr(14'h2000);
    pd_val = 8'h3C;
    applyStimulus(1'b0, 8'h00, 14'h0100);
    tick;
    CPU_REQ = 1'b0;
    tick;
    tick;
    V_LOAD = 1'b1;
    V_IN = 14'h0100;
    tick;
    V_LOAD = 1'b0;
    checkOutput("vload_wins", 32'(VADDR), 32'h0100);
    checkOutput("rbuf_vload", 32'(RBUF), 32'h3C);

    // Render window holds off a CPU request until it closes
    pd_val = 8'h77;
    FETCH_ADDR = 14'h1234;
    render_strobes = 0;
    for (int h = 0; h < 16; h++) begin
      RENDER = 1'b1;
      H = 9'(h);
      if (h == 3)
        applyStimulus(1'b0, 8'h00, 14'h0101);
      tick;
      CPU_REQ = 1'b0;
      checkOutput("grant_r", 32'(GRANT_R), 1);
      if (h >= 3)
        checkOutput("busy_hold", 32'(BUSY), 1);
    end
    RENDER = 1'b0;
    H = 9'd16;
    tick;
    checkOutput("grant_release", 32'(GRANT_R), 0);
    checkOutput("idle_busy", 32'(BUSY), 1);
    checkOutput("idle_ale", 32'(ALE), 0);
    checkOutput("render_count", 32'(render_strobes), 8);
    tick;
    checkOutput("cpu_ale_after_render", 32'(ALE), 1);
    checkOutput("cpu_pa_after_render", 32'(PA), 32'h0100);
    checkOutput("grant_cpu", 32'(GRANT_R), 0);
    tick;
    tick;
    checkOutput("vaddr_after_render", 32'(VADDR), 32'h0101);

    // Reset in the middle of a CPU read aborts it
    n_RES = 1'b0;
    tick;
    n_RES = 1'b1;
    model_v = '0;
    pd_val = 8'h99;
    applyStimulus(1'b0, 8'h00, 14'h0001);
    tick;
    CPU_REQ = 1'b0;
    tick;
    tick;
    checkOutput("crd_before_reset", 32'(n_RD), 0);
    n_RES = 1'b0;
    tick;
    checkOutput("abort_nrd", 32'(n_RD), 1);
    checkOutput("abort_nwr", 32'(n_WR), 1);
    checkOutput("abort_ale", 32'(ALE), 0);
    checkOutput("abort_busy", 32'(BUSY), 0);
    checkOutput("abort_pd_out", 32'(PD_OUT), 0);
    checkOutput("abort_pd_oe", 32'(PD_OE), 0);
    checkOutput("abort_err", 32'(ERR), 0);
    checkOutput("abort_vaddr_main", 32'(VADDR), 0);
    checkOutput("abort_rbuf_main", 32'(RBUF), 0);
    n_RES = 1'b1;
    tick;
    tick;
    checkOutput("pending_cleared_ale", 32'(ALE), 0);
    checkOutput("pending_cleared_busy", 32'(BUSY), 0);
    checkOutput("queue_drain", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
